// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_gen
// Description : Free-running PWM with a double-buffered duty word. The duty
//               is captured once per period so ramping din never glitches sout.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    // Period is 2^WIDTH-1, so the counter tops out at 2^WIDTH-2 and the
    // all-ones code is reserved for "always high".
    localparam logic [WIDTH-1:0] c_CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_duty;
    logic             r_sout;
    logic             w_wrap;

    assign w_wrap = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_sout <= 1'b0;
        end else begin
            r_sout <= (r_cnt < r_duty);
            if (w_wrap) begin
                r_cnt  <= '0;
                r_duty <= din;
            end else begin
                r_cnt  <= r_cnt + WIDTH'(1);
            end
        end
    end

    assign sout = r_sout;

endmodule
`default_nettype wire

// File: tb/tb_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_gen
// Description : Scoreboard bench for pwm_gen; period-arithmetic reference
//               model feeds a queue that a negedge monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_gen;

    localparam int c_WIDTH  = 8;
    localparam int c_PERIOD = (1 << c_WIDTH) - 1;

    logic               clk;
    logic               rst;
    logic [c_WIDTH-1:0] din;
    logic               sout;

    int   total;
    int   bad;
    bit   exp_q[$];
    bit   drv_done;

    // Model state: edges elapsed since reset release and the duty in force
    int   m_edges;
    int   m_duty_now;

    pwm_gen #(.WIDTH(c_WIDTH)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .sout (sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input logic r, input logic [c_WIDTH-1:0] d);
        int pos;
        bit want;
        if (r) begin
            m_edges    = 0;
            m_duty_now = 0;
            want       = 1'b0;
        end else begin
            pos  = m_edges % c_PERIOD;
            want = (pos < m_duty_now);
            if (pos == c_PERIOD - 1)
                m_duty_now = int'(d);
            m_edges++;
        end
        exp_q.push_back(want);
    endtask

    task automatic drive(input logic r, input logic [c_WIDTH-1:0] d);
        rst = r;
        din = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    task automatic run_periods(input int n, input logic [c_WIDTH-1:0] d);
        for (int i = 0; i < n * c_PERIOD; i++) drive(1'b0, d);
    endtask

    task automatic run_to_pos(input int target, input logic [c_WIDTH-1:0] d);
        int guard;
        guard = 0;
        while ((m_edges % c_PERIOD) != target && guard < 2 * c_PERIOD) begin
            drive(1'b0, d);
            guard++;
        end
    endtask

    initial begin
        bit want;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                total++;
                if (sout !== want) begin
                    bad++;
                    $display("FAIL sout t=%0t edge=%0d got=%b want=%b",
                             $time, m_edges, sout, want);
                end
            end
        end
    end

    initial begin
        logic [c_WIDTH-1:0] rd;
        total    = 0;
        bad      = 0;
        drv_done = 1'b0;
        m_edges  = 0;
        m_duty_now = 0;
        rst = 1'b1;
        din = 8'd200;
        #1;

        // Reset with a nonzero request, then a full period that must stay low
        for (int i = 0; i < 3; i++) drive(1'b1, 8'd200);
        run_periods(1, 8'd200);

        run_periods(3, 8'd0);
        run_periods(3, 8'd255);
        run_periods(3, 8'd128);

        // Mid-period change is deferred to the next boundary
        run_to_pos(0, 8'd10);
        run_to_pos(50, 8'd10);
        run_periods(3, 8'd100);

        // Reset while sout is high
        run_periods(2, 8'd200);
        run_to_pos(100, 8'd200);
        drive(1'b1, 8'd200);
        run_periods(3, 8'd200);

        // Randomized ramping with occasional resets
        rd = 8'($urandom);
        for (int i = 0; i < 8 * c_PERIOD; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rd = 8'd0;
                    1:       rd = 8'd255;
                    default: rd = 8'($urandom);
                endcase
            end
            drive(($urandom_range(0, 1499) == 0), rd);
        end

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        drv_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
